// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end and the IF/ID register.
package fetch_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    // addi x0, x0, 0: shown on the instruction output whenever nothing real has been fetched
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch front end: one outstanding imem read, registered {PC, instruction} toward IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_o and presents a NOP for misaligned redirect targets.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] ResetPC = 64'h0,
    parameter int unsigned     PcStep  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    PC_o,
    output logic [INSTR_W-1:0] instruction_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic               misalign_o,
`endif
    input  logic               ready_i
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pcNext;
    logic [PC_W-1:0]    w_pcInc;
    logic [PC_W-1:0]    w_redirectPc;
    logic               w_capture;
    logic               w_dropValid;

    logic               r_valid;
    logic [PC_W-1:0]    r_pcOut;
    logic [INSTR_W-1:0] r_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misPending;
    logic r_misalign;
    logic w_presentNop;
    logic w_misaligned;

    assign w_redirectPc = redirect_pc_i;
    assign w_misaligned = |redirect_pc_i[1:0];
`else
    assign w_redirectPc = redirect_pc_i & ~PC_W'(3);
`endif

    assign w_pcInc = r_pc + PC_W'(PcStep);

    // Reset is folded in so no request leaks out while the memory is also held in reset.
`ifdef FETCH_MISALIGN_CHECK_EN
    assign imem_req_o = (r_state == ISSUE) && !redirect_i && !reset_i && !r_misPending;
`else
    assign imem_req_o = (r_state == ISSUE) && !redirect_i && !reset_i;
`endif
    assign imem_addr_o   = r_pc;
    assign valid_o       = r_valid;
    assign PC_o          = r_pcOut;
    assign instruction_o = r_instr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ISSUE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A redirect overrides everything; a pending response must still be absorbed in DROP.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_capture   = 1'b0;
        w_dropValid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_presentNop = 1'b0;
`endif
        if (redirect_i) begin
            w_pcNext    = w_redirectPc;
            w_dropValid = 1'b1;
            if ((r_state == WAIT) || (r_state == DROP)) begin
                w_stateNext = imem_rvalid_i ? ISSUE : DROP;
            end else begin
                w_stateNext = ISSUE;
            end
        end else begin
            case (r_state)
                ISSUE: begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (r_misPending) begin
                        w_presentNop = 1'b1;
                        w_stateNext  = FULL;
                    end else begin
                        w_stateNext = WAIT;
                    end
`else
                    w_stateNext = WAIT;
`endif
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        w_capture   = 1'b1;
                        w_pcNext    = w_pcInc;
                        w_stateNext = FULL;
                    end
                end
                FULL: begin
                    if (ready_i) begin
                        w_dropValid = 1'b1;
                        w_stateNext = ISSUE;
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        w_stateNext = ISSUE;
                    end
                end
                default: w_stateNext = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pc    <= ResetPC;
            r_valid <= 1'b0;
            r_pcOut <= '0;
            r_instr <= NOP_INSTR;
        end else begin
            r_pc <= w_pcNext;
            if (w_capture) begin
                r_valid <= 1'b1;
                r_pcOut <= r_pc;
                r_instr <= imem_rdata_i;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            else if (w_presentNop) begin
                r_valid <= 1'b1;
                r_pcOut <= r_pc;
                r_instr <= NOP_INSTR;
            end
`endif
            else if (w_dropValid) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // pc_q stays on the bad target; the consumer is expected to redirect to a trap handler.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_misPending <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            if (redirect_i) begin
                r_misPending <= w_misaligned;
            end else if (w_presentNop) begin
                r_misPending <= 1'b0;
            end
            if (w_presentNop) begin
                r_misalign <= 1'b1;
            end else if (w_capture || w_dropValid) begin
                r_misalign <= 1'b0;
            end
        end
    end

    assign misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences, then random traffic
// against a transaction-level model. Honours FETCH_MISALIGN_CHECK_EN when defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic [63:0] PC_o;
    logic [31:0] instruction_o;
    logic        ready_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int compared = 0;
    int mismatched = 0;

    fetch_stage dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .valid_o      (valid_o),
        .PC_o         (PC_o),
        .instruction_o(instruction_o),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_o   (misalign_o),
`endif
        .ready_i      (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // The bench memory never answers in the same cycle as a request.
    always @(negedge clk_i) begin
        if (!reset_i && imem_rvalid_i) begin
            assert (!imem_req_o) else $error("[TB] FAIL protocol: rvalid coincides with a request");
        end
    end

    typedef struct {
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        expReq;
        logic [63:0] expAddr;
        logic        expValid;
        logic [63:0] expPc;
        logic [31:0] expInstr;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge for sampling.
    task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic rv,
                                 input logic [31:0] rd, input logic rdy);
        @(posedge clk_i);
        #1;
        reset_i       = 1'b0;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        ready_i       = rdy;
        @(negedge clk_i);
    endtask

    task automatic checkCycle(input string name, input logic eReq, input logic [63:0] eAddr,
                              input logic eValid, input logic [63:0] ePc, input logic [31:0] eInstr);
        checkOutput({name, ".req"}, 64'(imem_req_o), 64'(eReq));
        if (eReq) checkOutput({name, ".addr"}, imem_addr_o, eAddr);
        checkOutput({name, ".valid"}, 64'(valid_o), 64'(eValid));
        if (eValid) begin
            checkOutput({name, ".pc"}, PC_o, ePc);
            checkOutput({name, ".instr"}, 64'(instruction_o), 64'(eInstr));
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, ".valid"}, 64'(valid_o), 64'd0);
        checkOutput({name, ".pc"}, PC_o, 64'd0);
        checkOutput({name, ".instr"}, 64'(instruction_o), 64'(NOP));
        checkOutput({name, ".req"}, 64'(imem_req_o), 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput({name, ".misalign"}, 64'(misalign_o), 64'd0);
`endif
    endtask

    logic [63:0] qPc[$];
    logic [31:0] qInstr[$];
    logic [63:0] expPc;
    logic [63:0] memAddr;
    logic [63:0] tgt;
    logic        memPending;
    logic        memStale;
    int          memCount;
    int          transfers;

    initial begin
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[1]  = '{1'b1, 32'h00A00093, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 32'h00A00093};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 64'h4, 1'b0, 64'h0, 32'h0};
        vecs[4]  = '{1'b1, 32'h00100113, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 64'h4, 32'h00100113};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 64'h8, 1'b0, 64'h0, 32'h0};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkReset("reset");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 64'h0, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
            checkCycle($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                       vecs[i].expValid, vecs[i].expPc, vecs[i].expInstr);
        end

        // Redirect while waiting; the stale word arrives two cycles later.
        applyStimulus(1'b1, 64'h80, 1'b0, 32'h0, 1'b1);
        checkCycle("redirWait.a1", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("redirWait.a2", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hDEADBEEF, 1'b1);
        checkCycle("redirWait.a3", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("redirWait.a4", 1'b1, 64'h80, 1'b0, 64'h0, 32'h0);

        // Redirect and rvalid together.
        applyStimulus(1'b1, 64'h200, 1'b1, 32'h11111111, 1'b1);
        checkCycle("redirRv.b1", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("redirRv.b2", 1'b1, 64'h200, 1'b0, 64'h0, 32'h0);

        // Redirect while holding an instruction with ready high.
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h22222222, 1'b0);
        checkCycle("redirFull.c1", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h300, 1'b0, 32'h0, 1'b1);
        checkCycle("redirFull.c2", 1'b0, 64'h0, 1'b1, 64'h200, 32'h22222222);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("redirFull.c3", 1'b1, 64'h300, 1'b0, 64'h0, 32'h0);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00000033, 1'b1);
        checkCycle("wrap.d1", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 1'b1);
        checkCycle("wrap.d2", 1'b0, 64'h0, 1'b1, 64'h300, 32'h00000033);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("wrap.d3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00000044, 1'b1);
        checkCycle("wrap.d4", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("wrap.d5", 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00000044);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("wrap.d6", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);

        // Misaligned redirect target.
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00000055, 1'b0);
        checkCycle("mis.e1", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h102, 1'b0, 32'h0, 1'b0);
        checkCycle("mis.e2", 1'b0, 64'h0, 1'b1, 64'h0, 32'h00000055);
`ifdef FETCH_MISALIGN_CHECK_EN
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkCycle("mis.e3", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("mis.e4", 1'b0, 64'h0, 1'b1, 64'h102, NOP);
        checkOutput("mis.e4.misalign", 64'(misalign_o), 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkCycle("mis.e5", imem_req_o, imem_addr_o, 1'b0, 64'h0, 32'h0);
        checkOutput("mis.e5.misalign", 64'(misalign_o), 64'd0);
`else
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkCycle("mis.e3", 1'b1, 64'h100, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h00000066, 1'b0);
        checkCycle("mis.e4", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("mis.e5", 1'b0, 64'h0, 1'b1, 64'h100, 32'h00000066);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkCycle("mis.e6", 1'b1, 64'h104, 1'b0, 64'h0, 32'h0);
`endif

        // Asynchronous reset in the middle of a fetch; memory is reset with the block.
        @(posedge clk_i);
        #1;
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        ready_i       = 1'b0;
        @(negedge clk_i);
        checkReset("midReset");

        // Random traffic: the model tracks the expected fetch address and the queue of
        // instructions that must be delivered, independent of how the block sequences them.
        expPc      = 64'h0;
        memPending = 1'b0;
        memStale   = 1'b0;
        memAddr    = '0;
        memCount   = 0;
        transfers  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_i);
            #1;
            reset_i = 1'b0;
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) tgt[63:8] = '1;
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            redirect_i    = ($urandom_range(0, 11) == 0);
            redirect_pc_i = tgt;
            ready_i       = ($urandom_range(0, 9) < 7);
            imem_rvalid_i = memPending && (memCount == 0);
            imem_rdata_i  = $urandom;
            @(negedge clk_i);

            checkOutput("rnd.valid", 64'(valid_o), 64'(qPc.size() != 0));
            if (qPc.size() != 0) begin
                checkOutput("rnd.pc", PC_o, qPc[0]);
                checkOutput("rnd.instr", 64'(instruction_o), 64'(qInstr[0]));
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            checkOutput("rnd.misalign", 64'(misalign_o), 64'd0);
`endif
            if (valid_o && ready_i && !redirect_i && (qPc.size() != 0)) begin
                void'(qPc.pop_front());
                void'(qInstr.pop_front());
                transfers++;
            end
            if (imem_rvalid_i) begin
                memPending = 1'b0;
                if (!memStale && !redirect_i) begin
                    qPc.push_back(memAddr);
                    qInstr.push_back(imem_rdata_i);
                    expPc = memAddr + 64'd4;
                end
            end
            if (redirect_i) begin
                checkOutput("rnd.reqOnRedirect", 64'(imem_req_o), 64'd0);
                expPc = redirect_pc_i & ~64'd3;
                if (memPending) memStale = 1'b1;
                qPc.delete();
                qInstr.delete();
            end else if (imem_req_o) begin
                checkOutput("rnd.oneOutstanding", 64'(memPending), 64'd0);
                checkOutput("rnd.reqWhileValid", 64'(valid_o), 64'd0);
                checkOutput("rnd.addr", imem_addr_o, expPc);
                memPending = 1'b1;
                memStale   = 1'b0;
                memAddr    = imem_addr_o;
                memCount   = $urandom_range(0, 2);
            end else if (memPending && (memCount > 0)) begin
                memCount--;
            end
        end
        checkOutput("rnd.liveness", 64'(transfers >= 150), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
